// File: rtl/branch_pkg.sv
// Shared definitions for the branch controller: opcodes, FSM states, address type
// and the jump-target table.
package branch_pkg;

    typedef logic [5:0] addr_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    localparam logic [2:0] OP_HALT = 3'b100;
    localparam logic [2:0] OP_LDLC = 3'b101;
    localparam logic [2:0] OP_BCC  = 3'b110;
    localparam logic [2:0] OP_CTL  = 3'b111;

    localparam logic [1:0] SUB_JMP  = 2'b00;
    localparam logic [1:0] SUB_CALL = 2'b01;
    localparam logic [1:0] SUB_RET  = 2'b10;
    localparam logic [1:0] SUB_LOOP = 2'b11;

    localparam logic [5:0] HALT_IMM  = 6'h3F;
    localparam int         LUT_DEPTH = 16;

    // Jump-target table indexed by the 4-bit target field of the instruction.
    function automatic addr_t jump_lut(input logic [3:0] idx);
        addr_t t;
        case (idx)
            4'd0:    t = 6'd1;
            4'd1:    t = 6'd9;
            4'd2:    t = 6'd14;
            4'd3:    t = 6'd22;
            4'd4:    t = 6'd27;
            4'd5:    t = 6'd31;
            4'd6:    t = 6'd35;
            4'd7:    t = 6'd40;
            4'd8:    t = 6'd44;
            4'd9:    t = 6'd48;
            4'd10:   t = 6'd51;
            4'd11:   t = 6'd54;
            4'd12:   t = 6'd57;
            4'd13:   t = 6'd59;
            4'd14:   t = 6'd61;
            default: t = 6'd63;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack. Entry 0 is the oldest; a push into a full stack
// discards the oldest entry so the most recent return addresses survive.
module ras_stack
    import branch_pkg::*;
#(
    parameter int STACK_DEPTH = 2
) (
    input  logic  Clk,
    input  logic  Reset,
    input  logic  push,
    input  logic  pop,
    input  addr_t push_data,
    output logic  empty,
    output logic  full,
    output addr_t top
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    addr_t         entries [STACK_DEPTH];
    logic [CW-1:0] count;

    assign empty = (count == '0);
    assign full  = (count == CW'(STACK_DEPTH));

    // Newest entry sits at position count-1.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (CW'(i + 1) == count) top = entries[i];
        end
    end

    // Push/pop bookkeeping; a full push shifts everything down by one slot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) entries[i] <= '0;
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) entries[i] <= entries[i + 1];
                entries[STACK_DEPTH - 1] <= push_data;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (CW'(i) == count) entries[i] <= push_data;
                end
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Control-flow unit: decodes branch/jump/call/return/loop/halt and drives the
// program counter's jump interface combinationally from the current instruction.
//
// state  | meaning
// RUN    | executing; instructions decoded and state updated
// HALTED | HALT seen; PC held via Jen=1/Jump=PC until Reset
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int STACK_DEPTH = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [8:0] Instruction,
    input  logic [5:0] PC,
    input  logic       FlagWe,
    input  logic       FlagZero,
    output logic       Jen,
    output logic [5:0] Jump,
    output logic       halted,
    output logic       stack_err
);

    state_e     state;
    logic       zflag;
    logic [5:0] loop_cnt;

    logic       do_push;
    logic       do_pop;
    logic       ras_empty;
    logic       ras_full;
    addr_t      ras_top;

    logic [2:0] op;
    logic [1:0] sub;
    logic [5:0] imm;
    addr_t      target;

    assign op     = Instruction[8:6];
    assign sub    = Instruction[5:4];
    assign imm    = Instruction[5:0];
    assign target = jump_lut(Instruction[3:0]);

    // Decode: jump interface plus stack push/pop requests for this cycle.
    always_comb begin
        Jen     = 1'b0;
        Jump    = 6'd0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (Reset) begin
            Jen  = 1'b0;
            Jump = 6'd0;
        end else if (state == HALTED) begin
            Jen  = 1'b1;
            Jump = PC;
        end else begin
            case (op)
                OP_BCC: begin
                    // Instruction[5]=0 branches on zero, =1 on non-zero.
                    if (Instruction[5] ? !zflag : zflag) begin
                        Jen  = 1'b1;
                        Jump = target;
                    end
                end
                OP_CTL: begin
                    case (sub)
                        SUB_JMP: begin
                            Jen  = 1'b1;
                            Jump = target;
                        end
                        SUB_CALL: begin
                            Jen     = 1'b1;
                            Jump    = target;
                            do_push = 1'b1;
                        end
                        SUB_RET: begin
                            // Underflow returns to address 0.
                            Jen    = 1'b1;
                            Jump   = ras_empty ? 6'd0 : ras_top;
                            do_pop = 1'b1;
                        end
                        default: begin
                            // Taken iff the decremented count is still non-zero.
                            if (loop_cnt > 6'd1) begin
                                Jen  = 1'b1;
                                Jump = target;
                            end
                        end
                    endcase
                end
                OP_HALT: begin
                    if (imm == HALT_IMM) begin
                        Jen  = 1'b1;
                        Jump = PC;
                    end
                end
                default: begin
                    Jen  = 1'b0;
                    Jump = 6'd0;
                end
            endcase
        end
    end

    // FSM, zero flag, loop counter and sticky stack error.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= RUN;
            halted    <= 1'b0;
            zflag     <= 1'b0;
            loop_cnt  <= 6'd0;
            stack_err <= 1'b0;
        end else if (state == RUN) begin
            if (FlagWe) zflag <= FlagZero;
            if (op == OP_LDLC) loop_cnt <= imm;
            if (op == OP_CTL && sub == SUB_LOOP && loop_cnt != 6'd0)
                loop_cnt <= loop_cnt - 6'd1;
            if ((do_push && ras_full) || (do_pop && ras_empty))
                stack_err <= 1'b1;
            if (op == OP_HALT && imm == HALT_IMM) begin
                state  <= HALTED;
                halted <= 1'b1;
            end
        end
    end

    ras_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_ras (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (PC + 6'd1),
        .empty     (ras_empty),
        .full      (ras_full),
        .top       (ras_top)
    );

endmodule
